// File: rtl/ser_frame_arbiter_if.sv
// Request/grant and serial-line bundle between the four requesters and the
// frame arbiter. The arbiter uses the slave modport, the requester side uses master.
interface ser_frame_arbiter_if;
  logic [3:0]  req;
  logic [7:0]  hdr_dest;
  logic [23:0] hdr_len;
  logic [3:0]  bit_in;
  logic [3:0]  gnt;
  logic [3:0]  pay_ack;
  logic [3:0]  done;
  logic        sOut;
  logic        busy;

  modport master (
    output req, hdr_dest, hdr_len, bit_in,
    input  gnt, pay_ack, done, sOut, busy
  );

  modport slave (
    input  req, hdr_dest, hdr_len, bit_in,
    output gnt, pay_ack, done, sOut, busy
  );
endinterface

// File: rtl/ser_frame_arbiter.sv
// Round-robin four-way arbiter that serializes the granted frame onto one line:
// start bit, 8-bit header (dest, len; LSB first), 8*len payload bits, stop, idle gap.
module ser_frame_arbiter #(
  parameter int unsigned IDLE_GAP = 2
) (
  input logic                 clk,
  input logic                 rst,
  ser_frame_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_HDR, S_PAY, S_STOP, S_GAP
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  hdr_q, hdr_d;
  logic [2:0]  hcnt_q, hcnt_d;
  logic [8:0]  pcnt_q, pcnt_d;
  logic [3:0]  gcnt_q, gcnt_d;
  logic [3:0]  gnt_q, gnt_d;
  logic        sout_q, sout_d;

  logic        win_found;
  logic [1:0]  win_idx;
  logic [1:0]  cand;
  logic [5:0]  len_q;
  logic        ack_en;

  assign len_q = hdr_q[7:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      hdr_q   <= '0;
      hcnt_q  <= '0;
      pcnt_q  <= '0;
      gcnt_q  <= '0;
      gnt_q   <= '0;
      sout_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      hdr_q   <= hdr_d;
      hcnt_q  <= hcnt_d;
      pcnt_q  <= pcnt_d;
      gcnt_q  <= gcnt_d;
      gnt_q   <= gnt_d;
      sout_q  <= sout_d;
    end
  end

  // Round-robin search starting at the pointer (last winner + 1).
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    hdr_d   = hdr_q;
    hcnt_d  = hcnt_q;
    pcnt_d  = pcnt_q;
    gcnt_d  = gcnt_q;
    gnt_d   = gnt_q;
    sout_d  = sout_q;
    unique case (state_q)
      S_IDLE: begin
        sout_d = 1'b1;
        if (win_found) begin
          state_d = S_START;
          idx_d   = win_idx;
          ptr_d   = win_idx + 2'd1;
          hdr_d   = {bus.hdr_len[6*int'(win_idx) +: 6], bus.hdr_dest[2*int'(win_idx) +: 2]};
          gnt_d   = 4'b0001 << win_idx;
          sout_d  = 1'b0;
        end
      end
      S_START: begin
        state_d = S_HDR;
        hcnt_d  = '0;
        sout_d  = hdr_q[0];
      end
      S_HDR: begin
        if (hcnt_q == 3'd7) begin
          // First payload bit is captured on the edge closing the last header bit.
          if (len_q != '0) begin
            state_d = S_PAY;
            pcnt_d  = {len_q, 3'b000};
            sout_d  = bus.bit_in[idx_q];
          end else begin
            state_d = S_STOP;
            sout_d  = 1'b1;
          end
        end else begin
          hcnt_d = hcnt_q + 3'd1;
          sout_d = hdr_q[hcnt_q + 3'd1];
        end
      end
      S_PAY: begin
        if (pcnt_q == 9'd1) begin
          state_d = S_STOP;
          sout_d  = 1'b1;
        end else begin
          pcnt_d = pcnt_q - 9'd1;
          sout_d = bus.bit_in[idx_q];
        end
      end
      S_STOP: begin
        state_d = S_GAP;
        gnt_d   = '0;
        gcnt_d  = 4'(IDLE_GAP - 1);
        sout_d  = 1'b1;
      end
      S_GAP: begin
        sout_d = 1'b1;
        if (gcnt_q == '0) state_d = S_IDLE;
        else              gcnt_d  = gcnt_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ack_en = ((state_q == S_HDR) && (hcnt_q == 3'd7) && (len_q != '0)) ||
                  ((state_q == S_PAY) && (pcnt_q != 9'd1));

  assign bus.gnt     = gnt_q;
  assign bus.sOut    = sout_q;
  assign bus.busy    = (state_q != S_IDLE);
  assign bus.pay_ack = ack_en ? (4'b0001 << idx_q) : 4'b0000;
  assign bus.done    = (state_q == S_STOP) ? (4'b0001 << idx_q) : 4'b0000;

endmodule

// File: tb/tb_ser_frame_arbiter.sv
// Directed self-checking bench for ser_frame_arbiter.
module tb_ser_frame_arbiter;
  localparam int G = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests_run = 0;
  int   fails = 0;

  ser_frame_arbiter_if bus();

  ser_frame_arbiter #(.IDLE_GAP(G)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    bus.req = '0; bus.hdr_dest = '0; bus.hdr_len = '0; bus.bit_in = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    bus.req = '0; bus.hdr_dest = '0; bus.hdr_len = '0; bus.bit_in = '0;
    #1 rst = 1'b1;
    #1;
    tests_run++; if (bus.sOut !== 1'b1) begin fails++; $display("FAIL reset_sOut: got %b expected 1", bus.sOut); end
    tests_run++; if (bus.gnt !== 4'b0) begin fails++; $display("FAIL reset_gnt: got %b expected 0000", bus.gnt); end
    tests_run++; if (bus.pay_ack !== 4'b0) begin fails++; $display("FAIL reset_pay_ack: got %b expected 0000", bus.pay_ack); end
    tests_run++; if (bus.done !== 4'b0) begin fails++; $display("FAIL reset_done: got %b expected 0000", bus.done); end
    tests_run++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    tick();
    rst = 1'b0;
    tick(); tick();
    tests_run++; if (bus.busy !== 1'b0 || bus.sOut !== 1'b1) begin fails++; $display("FAIL idle_no_req: got busy=%b sOut=%b expected busy=0 sOut=1", bus.busy, bus.sOut); end
  endtask

  task automatic test_reset_mid_pay;
    apply_reset();
    bus.req = 4'b0001; bus.hdr_len[5:0] = 6'd2; bus.bit_in = '0;
    tick();
    bus.req = '0;
    for (int i = 0; i < 14; i++) tick();
    tests_run++; if (bus.busy !== 1'b1 || bus.gnt !== 4'b0001) begin fails++; $display("FAIL midpay_active: got busy=%b gnt=%b expected busy=1 gnt=0001", bus.busy, bus.gnt); end
    #2 rst = 1'b1;
    #1;
    tests_run++; if (bus.sOut !== 1'b1) begin fails++; $display("FAIL midpay_rst_sOut: got %b expected 1", bus.sOut); end
    tests_run++; if (bus.gnt !== 4'b0) begin fails++; $display("FAIL midpay_rst_gnt: got %b expected 0000", bus.gnt); end
    tests_run++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL midpay_rst_busy: got %b expected 0", bus.busy); end
    #1 rst = 1'b0;
    bus.req = 4'b0100; bus.hdr_len[17:12] = 6'd0;
    tick();
    tests_run++; if (bus.gnt !== 4'b0100) begin fails++; $display("FAIL midpay_regrant: got %b expected 0100", bus.gnt); end
    tests_run++; if (bus.sOut !== 1'b0) begin fails++; $display("FAIL midpay_regrant_start: got %b expected 0", bus.sOut); end
    bus.req = '0;
  endtask

  task automatic test_single;
    logic exp_bits [18] = '{1'b0, 1'b0,1'b1, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,
                            1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b1, 1'b1};
    logic [7:0] pl;
    int pi;
    int acks;
    pl = 8'hA5; pi = 0; acks = 0;
    apply_reset();
    bus.req = 4'b0001; bus.hdr_dest[1:0] = 2'b10; bus.hdr_len[5:0] = 6'd1;
    tick();
    bus.req = '0;
    tests_run++; if (bus.gnt !== 4'b0001) begin fails++; $display("FAIL single_gnt: got %b expected 0001", bus.gnt); end
    for (int k = 0; k < 18; k++) begin
      tests_run++; if (bus.sOut !== exp_bits[k]) begin fails++; $display("FAIL single_bit%0d: got %b expected %b", k, bus.sOut, exp_bits[k]); end
      if (k == 17) begin
        tests_run++; if (bus.done !== 4'b0001) begin fails++; $display("FAIL single_done: got %b expected 0001", bus.done); end
      end
      if (bus.pay_ack[0]) begin
        acks++;
        if (pi < 8) begin bus.bit_in[0] = pl[7 - pi]; pi++; end
      end
      tick();
    end
    tests_run++; if (bus.gnt !== 4'b0) begin fails++; $display("FAIL single_gnt_drop: got %b expected 0000", bus.gnt); end
    tests_run++; if (bus.done !== 4'b0) begin fails++; $display("FAIL single_done_clear: got %b expected 0000", bus.done); end
    tests_run++; if (acks != 8) begin fails++; $display("FAIL single_acks: got %0d expected 8", acks); end
  endtask

  task automatic test_round_robin;
    logic [3:0] order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] prev;
    int gcount, last, hi, cyc;
    bit ack_seen;
    prev = '0; gcount = 0; last = 0; hi = 0; cyc = 0; ack_seen = 0;
    apply_reset();
    bus.req = 4'b1111;
    while (cyc < 100 && gcount < 5) begin
      tick();
      cyc++;
      if (bus.pay_ack !== 4'b0) ack_seen = 1;
      if (prev != 4'b0 && bus.gnt == 4'b0) begin
        tests_run++; if (hi != 10) begin fails++; $display("FAIL rr_frame_len%0d: got %0d expected 10", gcount, hi); end
      end
      if (bus.gnt != 4'b0 && prev == 4'b0) begin
        tests_run++; if (bus.gnt !== order[gcount]) begin fails++; $display("FAIL rr_order%0d: got %b expected %b", gcount, bus.gnt, order[gcount]); end
        if (gcount > 0) begin
          tests_run++; if (cyc - last != 10 + G + 1) begin fails++; $display("FAIL rr_spacing%0d: got %0d expected %0d", gcount, cyc - last, 10 + G + 1); end
        end
        last = cyc; gcount++; hi = 0;
      end
      if (bus.gnt != 4'b0) hi++;
      prev = bus.gnt;
    end
    tests_run++; if (gcount != 5) begin fails++; $display("FAIL rr_grant_count: got %0d expected 5", gcount); end
    tests_run++; if (ack_seen) begin fails++; $display("FAIL rr_no_ack: got pay_ack activity expected none"); end
    bus.req = '0;
  endtask

  task automatic test_max_len;
    int k, acks, stopk;
    bit stray;
    k = 1; acks = 0; stopk = -1; stray = 0;
    apply_reset();
    bus.req = 4'b1000; bus.hdr_len[23:18] = 6'd63; bus.bit_in = '0;
    tick();
    bus.req = '0;
    while (k <= 600 && stopk < 0) begin
      if (bus.pay_ack[3]) acks++;
      if ((bus.pay_ack & 4'b0111) != 4'b0) stray = 1;
      if (bus.done[3]) begin
        stopk = k;
        tests_run++; if (bus.sOut !== 1'b1) begin fails++; $display("FAIL max_stop_bit: got %b expected 1", bus.sOut); end
      end
      tick();
      k++;
    end
    tests_run++; if (acks != 504) begin fails++; $display("FAIL max_acks: got %0d expected 504", acks); end
    tests_run++; if (stopk != 514) begin fails++; $display("FAIL max_stop_cycle: got %0d expected 514", stopk); end
    tests_run++; if (stray) begin fails++; $display("FAIL max_stray_ack: got ack on other requester expected none"); end
    for (int i = 0; i < G; i++) tick();
    tests_run++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL max_idle: got busy=%b expected 0", bus.busy); end
  endtask

  task automatic test_drop_mid_hdr;
    int k, acks, stopk, w;
    k = 1; acks = 0; stopk = -1; w = 0;
    apply_reset();
    bus.req = 4'b0010; bus.hdr_dest[3:2] = 2'b01; bus.hdr_len[11:6] = 6'd1;
    tick();
    tests_run++; if (bus.gnt !== 4'b0010) begin fails++; $display("FAIL drop_gnt: got %b expected 0010", bus.gnt); end
    tick(); tick(); k = 3;
    bus.req = '0; bus.hdr_len[11:6] = 6'd5;
    while (k < 100 && stopk < 0) begin
      if (bus.pay_ack[1]) acks++;
      if (bus.done[1]) stopk = k;
      tick();
      k++;
    end
    tests_run++; if (acks != 8) begin fails++; $display("FAIL drop_acks: got %0d expected 8", acks); end
    tests_run++; if (stopk != 18) begin fails++; $display("FAIL drop_stop_cycle: got %0d expected 18", stopk); end
    while (bus.busy && w < 20) begin tick(); w++; end
    tests_run++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL drop_idle: got busy=%b expected 0", bus.busy); end
    bus.req = 4'b0101;
    tick();
    tests_run++; if (bus.gnt !== 4'b0100) begin fails++; $display("FAIL drop_rr_next: got %b expected 0100", bus.gnt); end
    bus.req = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_reset_mid_pay();
    test_single();
    test_round_robin();
    test_max_len();
    test_drop_mid_hdr();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule

// File: doc/ser_frame_arbiter.md
# ser_frame_arbiter

Transmit-side scheduler for the serial demultiplexer link. It shares one serial line among four requesters, arbitrates round-robin, and serializes each granted frame onto `sOut`. A frame is a start bit, an 8-bit header (2-bit destination port, 6-bit byte count) and payload bits, followed by a stop bit and a configurable idle gap. It sits upstream of the serial receiver/demux and drives its `sIn`.

## Interface
- `IDLE_GAP`, default 2: idle-high cycles forced after each stop bit, legal range 1..15.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `req` in 4: per-requester frame request, level.
- `hdr_dest` in 8: destination port, 2 bits per requester; requester i uses [2i+1:2i].
- `hdr_len` in 24: payload byte count, 6 bits per requester; requester i uses [6i+5:6i].
- `bit_in` in 4: per-requester payload bit.
- `gnt` out 4: one-hot grant, held for the whole frame.
- `pay_ack` out 4: one-hot; high in the cycle whose closing edge samples `bit_in[i]`.
- `done` out 4: one-cycle pulse to requester i during its stop-bit cycle.
- `sOut` out 1: serial line; idle 1.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- States: IDLE, START, HDR, PAY, STOP, GAP.
- IDLE:
  - `sOut`=1.
  - If `req`≠0, the edge selects the winner, latches its `hdr_dest`/`hdr_len`, sets `gnt`, sets `sOut`<=0 and moves to START.
  - If `req`=0, stay in IDLE.
- Arbitration:
  - Round-robin over the 4 requesters.
  - The search starts at (last granted + 1) mod 4. After reset the pointer is 0, so requester 0 has top priority.
  - The pointer updates at grant.
- START: 1 cycle, `sOut`=0. The edge loads header bit 0.
- HDR: 8 cycles.
  - Bit order on `sOut`: d0, d1, l0, l1, l2, l3, l4, l5 (LSB first).
  - A 3-bit counter tracks position. On the last header cycle, the state goes to PAY if len≠0, otherwise to STOP.
- PAY: exactly 8×len cycles, using a 9-bit down-counter loaded with {len,3'b000} and decremented per bit.
  - The first payload bit is sampled at the closing edge of the last HDR cycle, so `pay_ack` is also high in that cycle.
  - `pay_ack` is high in every PAY cycle except the last.
  - `sOut` is registered: each payload bit appears in the cycle after its sampling edge.
  - `bit_in` of non-granted requesters is ignored.
- STOP: 1 cycle.
  - `sOut`=1.
  - `done[idx]` pulses.
  - Next state is GAP.
- GAP: `IDLE_GAP` cycles.
  - `sOut`=1 and `gnt`=0, with `gnt` cleared on entry to GAP.
  - Requests are not evaluated until the state returns to IDLE.
- Latched header and winner index are immune to input changes after grant.
- Dropping `req` mid-frame does not abort the frame. It still completes with whatever `bit_in` presents.
- `hdr_len`=0: the frame is START + HDR + STOP (10 line bits) with no `pay_ack`.
- Maximum frame: len=63 gives 504 payload bits. The counter must not wrap.

## Timing
- Reset values: `sOut`=1, `gnt`=0, `pay_ack`=0, `done`=0, `busy`=0, state IDLE, RR pointer 0. Reset takes effect immediately (asynchronous), including mid-frame; the partial frame is abandoned.
- All outputs are registered or decoded from registered state only; there is no combinational path from inputs to outputs.
- Grant latency: `req` seen at edge E0 gives `gnt` and `sOut`=0 in cycle E0+1.
- Frame line length: 1 + 8 + 8×len + 1 cycles. Grant-to-next-possible-grant is that length + `IDLE_GAP` + 1 cycles (the +1 is the IDLE cycle).
- Simultaneous requests: exactly one grant per arbitration; losers are served in round-robin order in later frames.
- `req` rising during GAP is treated as pending and is evaluated on the first IDLE cycle.

## Test plan
- Reset mid-PAY (rst pulse during cycle 15 of a len=2 frame) -> `sOut`=1, `gnt`=0, `busy`=0 immediately, without waiting for a clock edge. The next frame with `req`=4'b0100 is granted to requester 2.
- Single request (req0, dest=2'b10, len=1, payload 8'hA5 fed on `pay_ack`) -> `sOut` from cycle E0+1 reads 0, 0,1, 1,0,0,0,0,0, 1,0,1,0,0,1,0,1, 1. `done[0]` pulses on the stop cycle and `gnt` drops after it.
- `req`=4'b1111 held, all len=0 -> grants in order 0,1,2,3,0. Each frame is 10 line bits, `pay_ack` stays 0, and grants are spaced 10+`IDLE_GAP`+1 cycles apart.
- len=63 on requester 3 -> exactly 504 `pay_ack` cycles, no counter wrap, and stop bit at cycle E0+514.
- `req`1 dropped and `hdr_len`1 changed mid-HDR -> the frame completes with the originally latched length. `done[1]` pulses, and the RR pointer then favours requester 2.
